tdc_capture: RTL and testbench

TDC_CAPTURE -- requirements
Module: tdc_capture

---
 rtl/tdc_capture_if.sv | 24 ++
 rtl/tdc_capture.sv | 144 ++++++++++++++
 tb/tb_tdc_capture.sv | 118 +++++++++++
 3 files changed

// File: rtl/tdc_capture_if.sv
// Sample/result bundle between the DCO sampler front end and the TDC capture block.
// The capture block uses the slave modport. The sampler or the bench uses the master modport.
interface tdc_capture_if #(
  parameter int CNTW = 7,
  parameter int PHW  = 16
);
  logic            en;
  logic            tdc_pd;
  logic [CNTW-1:0] counter_in;
  logic [PHW-1:0]  phase_in;
  logic [11:0]     tdc_word;
  logic            tdc_valid;
  logic            phase_err;

  modport master (
    output en, tdc_pd, counter_in, phase_in,
    input  tdc_word, tdc_valid, phase_err
  );

  modport slave (
    input  en, tdc_pd, counter_in, phase_in,
    output tdc_word, tdc_valid, phase_err
  );
endinterface

// File: rtl/tdc_capture.sv
// Turns DCO ripple-counter and thermometer-phase samples into a fractional count of DCO periods per reference cycle.
// Stage 1 registers the raw sample. Stage 2 differences the decoded position against the previous one.
module tdc_capture #(
  parameter int CNTW  = 7,
  parameter int PHW   = 16,
  parameter int FINEW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tdc_capture_if.slave bus
);

  localparam int PW       = CNTW + FINEW;
  localparam int FINE_MAX = (1 << FINEW) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Length of the unbroken run of ones starting at tap 0, clipped to the width of the fine field.
  function automatic logic [FINEW-1:0] fine_decode(input logic [PHW-1:0] ph);
    int   n;
    logic in_run;
    n      = 0;
    in_run = 1'b1;
    for (int i = 0; i < PHW; i++) begin
      if (in_run && ph[i]) begin
        n = n + 1;
      end else begin
        in_run = 1'b0;
      end
    end
    if (n > FINE_MAX) begin
      return FINEW'(FINE_MAX);
    end else begin
      return FINEW'(n);
    end
  endfunction

  // A clean code has the form 0..01..1. Adding one gives a power of two (or zero when every bit is set).
  function automatic logic therm_bubble(input logic [PHW-1:0] ph);
    return ((ph & (ph + PHW'(1))) != '0);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_prime;
  logic              w_run;
  logic [CNTW-1:0]   r_cnt_s;
  logic [PHW-1:0]    r_ph_s;
  logic [PW-1:0]     r_p_last;
  logic [FINEW-1:0]  r_fine_last;
  logic [11:0]       r_tdc_word;
  logic              r_tdc_valid;
  logic              r_phase_err;
  logic [FINEW-1:0]  w_fine_raw;
  logic              w_bubble;
  logic [FINEW-1:0]  w_fine;
  logic [PW-1:0]     w_pos;
  logic [PW-1:0]     w_diff;

  assign w_fine_raw = fine_decode(r_ph_s);
  assign w_bubble   = therm_bubble(r_ph_s);
  assign w_fine     = w_bubble ? r_fine_last : w_fine_raw;
  assign w_pos      = {r_cnt_s, w_fine};
  assign w_diff     = w_pos - r_p_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes. Power-down overrides every state while enabled.
  always_comb begin
    w_state_nxt = r_state;
    w_prime     = 1'b0;
    w_run       = 1'b0;
    if (bus.en) begin
      if (bus.tdc_pd) begin
        w_state_nxt = IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            w_state_nxt = PRIME;
          end
          PRIME: begin
            w_state_nxt = RUN;
            w_prime     = 1'b1;
          end
          RUN: begin
            w_state_nxt = RUN;
            w_run       = 1'b1;
          end
          default: begin
            w_state_nxt = IDLE;
          end
        endcase
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Sample capture, position history and registered outputs. Valid and error flags are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_s     <= '0;
      r_ph_s      <= '0;
      r_p_last    <= '0;
      r_fine_last <= '0;
      r_tdc_word  <= 12'h000;
      r_tdc_valid <= 1'b0;
      r_phase_err <= 1'b0;
    end else if (bus.en) begin
      r_cnt_s     <= bus.counter_in;
      r_ph_s      <= bus.phase_in;
      r_tdc_valid <= w_run;
      r_phase_err <= w_run & w_bubble;
      if (w_prime || w_run) begin
        r_p_last <= w_pos;
        if (!w_bubble) begin
          r_fine_last <= w_fine_raw;
        end
      end
      if (w_run) begin
        r_tdc_word <= 12'(w_diff);
      end
    end else begin
      r_tdc_valid <= 1'b0;
      r_phase_err <= 1'b0;
    end
  end

  assign bus.tdc_word  = r_tdc_word;
  assign bus.tdc_valid = r_tdc_valid;
  assign bus.phase_err = r_phase_err;

endmodule

// File: tb/tb_tdc_capture.sv
// Directed bench for tdc_capture: a table of per-edge vectors plus a hand sequence for reset mid-RUN.
// It checks the outputs 1 ns after each rising edge.
module tb_tdc_capture;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tdc_capture_if #(.CNTW(7), .PHW(16)) bus ();

  tdc_capture #(.CNTW(7), .PHW(16), .FINEW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        pd;
    logic [6:0]  cnt;
    logic [15:0] ph;
    logic        valid;
    logic        err;
    logic [11:0] word;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic en, input logic pd, input logic [6:0] cnt,
                              input logic [15:0] ph, input logic valid, input logic err,
                              input logic [11:0] word);
    vec_t v;
    v.en = en; v.pd = pd; v.cnt = cnt; v.ph = ph;
    v.valid = valid; v.err = err; v.word = word;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got 0x%03h expected 0x%03h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.en         = v.en;
    bus.tdc_pd     = v.pd;
    bus.counter_in = v.cnt;
    bus.phase_in   = v.ph;
    @(posedge clk);
    #1;
    chk("valid", idx, {11'd0, bus.tdc_valid}, {11'd0, v.valid});
    chk("perr",  idx, {11'd0, bus.phase_err}, {11'd0, v.err});
    chk("word",  idx, bus.tdc_word, v.word);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Expected word = (P - P_last) mod 2048, with P = {counter, fine}, taken one sample behind the inputs.
    vecs[0]  = mk(1'b1, 1'b0, 7'h00, 16'h00FF, 1'b0, 1'b0, 12'h000); // IDLE->PRIME
    vecs[1]  = mk(1'b1, 1'b0, 7'h4B, 16'h00FF, 1'b0, 1'b0, 12'h000); // PRIME->RUN
    vecs[2]  = mk(1'b1, 1'b0, 7'h16, 16'h00FF, 1'b1, 1'b0, 12'h4B0); // ramp, 3rd edge
    vecs[3]  = mk(1'b1, 1'b0, 7'h61, 16'h00F7, 1'b1, 1'b0, 12'h4B0);
    vecs[4]  = mk(1'b1, 1'b0, 7'h2C, 16'h00FF, 1'b1, 1'b1, 12'h4B0); // bubble decoded, fine_last=8
    vecs[5]  = mk(1'b1, 1'b0, 7'h77, 16'h0FFF, 1'b1, 1'b0, 12'h4B0); // clean again
    vecs[6]  = mk(1'b1, 1'b0, 7'h42, 16'h0FFF, 1'b1, 1'b0, 12'h4B4); // fine 8 -> 12
    vecs[7]  = mk(1'b1, 1'b0, 7'h7E, 16'h0000, 1'b1, 1'b0, 12'h4B0);
    vecs[8]  = mk(1'b1, 1'b0, 7'h05, 16'h0000, 1'b1, 1'b0, 12'h3B4); // 0x7E0 - 0x42C
    vecs[9]  = mk(1'b1, 1'b0, 7'h05, 16'h0000, 1'b1, 1'b0, 12'h070); // wrap 0x7E -> 0x05
    vecs[10] = mk(1'b0, 1'b0, 7'h33, 16'hFFFF, 1'b0, 1'b0, 12'h070); // en low: hold
    vecs[11] = mk(1'b1, 1'b0, 7'h10, 16'hFFFF, 1'b1, 1'b0, 12'h000); // resume, no re-prime
    vecs[12] = mk(1'b1, 1'b0, 7'h10, 16'hFFFF, 1'b1, 1'b0, 12'h0BF); // all ones -> fine 15
    vecs[13] = mk(1'b1, 1'b1, 7'h20, 16'h00F7, 1'b0, 1'b0, 12'h0BF); // power-down, word held
    vecs[14] = mk(1'b1, 1'b1, 7'h20, 16'h00FF, 1'b0, 1'b0, 12'h0BF); // bubble under pd: no error
    vecs[15] = mk(1'b1, 1'b0, 7'h30, 16'h00FF, 1'b0, 1'b0, 12'h0BF); // IDLE->PRIME
    vecs[16] = mk(1'b1, 1'b0, 7'h40, 16'h00FF, 1'b0, 1'b0, 12'h0BF); // PRIME->RUN
    vecs[17] = mk(1'b1, 1'b0, 7'h50, 16'h00FF, 1'b1, 1'b0, 12'h100); // valid resumes

    bus.en         = 1'b0;
    bus.tdc_pd     = 1'b0;
    bus.counter_in = 7'h00;
    bus.phase_in   = 16'h0000;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_valid", 0, {11'd0, bus.tdc_valid}, 12'h000);
    chk("rst_perr",  0, {11'd0, bus.phase_err}, 12'h000);
    chk("rst_word",  0, bus.tdc_word, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i], i);
    end

    // Reset mid-RUN: the outputs clear immediately, and three edges pass before the next valid word.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 0, {11'd0, bus.tdc_valid}, 12'h000);
    chk("mid_rst_word",  0, bus.tdc_word, 12'h000);
    chk("mid_rst_perr",  0, {11'd0, bus.phase_err}, 12'h000);
    #3 rst_n = 1'b1;
    apply(mk(1'b1, 1'b0, 7'h00, 16'h00FF, 1'b0, 1'b0, 12'h000), 100);
    apply(mk(1'b1, 1'b0, 7'h4B, 16'h00FF, 1'b0, 1'b0, 12'h000), 101);
    apply(mk(1'b1, 1'b0, 7'h16, 16'h00FF, 1'b1, 1'b0, 12'h4B0), 102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
